// File: rtl/jtag_er2_sched_if.sv
// ER2 scheduler bus: JTAG-side controls, per-IP enables/TDO, and status.
// Optional ER2_SHIFT_COUNT_EN adds shift_len/last_len.
interface jtag_er2_sched_if #(
  parameter int unsigned NUM_IP = 15
);
  logic              jce2;
  logic              jshift;
  logic              jupdate;
  logic              control_datan;
  logic [NUM_IP-1:0] ip_enable;
  logic [NUM_IP-1:0] ip_tdo;
  logic              er2_tdo;
  logic [NUM_IP-1:0] ip_ce2;
  logic [NUM_IP-1:0] ip_update;
  logic [3:0]        active_ip;
  logic              busy;
  logic [7:0]        conflict_cnt;
`ifdef ER2_SHIFT_COUNT_EN
  logic [15:0]       shift_len;
  logic [15:0]       last_len;

  modport master (
    output jce2, jshift, jupdate, control_datan, ip_enable, ip_tdo,
    input  er2_tdo, ip_ce2, ip_update, active_ip, busy, conflict_cnt,
           shift_len, last_len
  );
  modport slave (
    input  jce2, jshift, jupdate, control_datan, ip_enable, ip_tdo,
    output er2_tdo, ip_ce2, ip_update, active_ip, busy, conflict_cnt,
           shift_len, last_len
  );
`else
  modport master (
    output jce2, jshift, jupdate, control_datan, ip_enable, ip_tdo,
    input  er2_tdo, ip_ce2, ip_update, active_ip, busy, conflict_cnt
  );
  modport slave (
    input  jce2, jshift, jupdate, control_datan, ip_enable, ip_tdo,
    output er2_tdo, ip_ce2, ip_update, active_ip, busy, conflict_cnt
  );
`endif
endinterface

// File: rtl/jtag_er2_sched.sv
// ER2 access scheduler: locks one IP per session, gates its ce2/TDO, pulses update.
// Optional shift-length counters enabled by macro ER2_SHIFT_COUNT_EN.
module jtag_er2_sched #(
  parameter int unsigned NUM_IP = 15
) (
  input  logic               jtck,
  input  logic               jrstn,
  jtag_er2_sched_if.slave    bus
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam logic [IDX_W-1:0] SEL_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_UPDATE = 2'd2,
    S_ERROR  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   active_ip_q, active_ip_d;
  logic               busy_q, busy_d;
  logic [NUM_IP-1:0]  ip_update_q, ip_update_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   en_idx;
  logic [IDX_W-1:0]   en_cnt;
  logic               en_onehot;
  logic               en_multi;
  logic [IDX_W-1:0]   cur;
  logic [NUM_IP-1:0]  sel_dec;
  logic [NUM_IP-1:0]  ce2_c;
  logic               tdo_c;
  logic               unused_inputs;

  // control_datan is consumed by the IPs; jshift only feeds the optional counters
  assign unused_inputs = ^{bus.control_datan, bus.jshift};

  // Popcount and index of ip_enable; index is only meaningful when one-hot
  always_comb begin
    en_idx = SEL_NONE;
    en_cnt = '0;
    for (int unsigned i = 0; i < NUM_IP; i++) begin
      if (bus.ip_enable[i]) begin
        en_idx = IDX_W'(i);
        en_cnt = en_cnt + IDX_W'(1);
      end
    end
  end

  assign en_onehot = (en_cnt == IDX_W'(1));
  assign en_multi  = (en_cnt > IDX_W'(1));

  // Current target: live decode while idle, locked selection while active
  always_comb begin
    cur = SEL_NONE;
    case (state_q)
      S_IDLE:   cur = en_onehot ? en_idx : SEL_NONE;
      S_ACTIVE: cur = sel_q;
      default:  cur = SEL_NONE;
    endcase
  end

  always_comb begin
    ce2_c   = '0;
    tdo_c   = 1'b0;
    sel_dec = '0;
    for (int unsigned i = 0; i < NUM_IP; i++) begin
      ce2_c[i]   = bus.jce2 && (cur == IDX_W'(i));
      sel_dec[i] = (sel_q == IDX_W'(i));
      if (cur == IDX_W'(i)) tdo_c = bus.ip_tdo[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    ip_update_d = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.jce2) begin
          if (en_onehot) begin
            state_d = S_ACTIVE;
            sel_d   = en_idx;
          end else if (en_multi) begin
            state_d = S_ERROR;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_ACTIVE: begin
        if (bus.jupdate) begin
          state_d     = S_UPDATE;
          ip_update_d = sel_dec;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
        sel_d   = SEL_NONE;
      end
      S_ERROR: begin
        if (bus.jupdate) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
    busy_d      = (state_d == S_ACTIVE) || (state_d == S_ERROR);
    active_ip_d = ((state_d == S_ACTIVE) || (state_d == S_UPDATE)) ? sel_d : SEL_NONE;
  end

  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_NONE;
      active_ip_q <= SEL_NONE;
      busy_q      <= 1'b0;
      ip_update_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      active_ip_q <= active_ip_d;
      busy_q      <= busy_d;
      ip_update_q <= ip_update_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ip_ce2       = ce2_c;
  assign bus.er2_tdo      = tdo_c;
  assign bus.ip_update    = ip_update_q;
  assign bus.active_ip    = active_ip_q;
  assign bus.busy         = busy_q;
  assign bus.conflict_cnt = cnt_q;

`ifdef ER2_SHIFT_COUNT_EN
  localparam int unsigned LEN_W = 16;

  logic [LEN_W-1:0] shift_len_q, shift_len_d;
  logic [LEN_W-1:0] last_len_q, last_len_d;

  // Shift cycles of the current session; snapshot taken while in UPDATE
  always_comb begin
    shift_len_d = shift_len_q;
    last_len_d  = last_len_q;
    if ((state_q == S_IDLE) && (state_d == S_ACTIVE)) begin
      shift_len_d = '0;
    end else if ((state_q == S_ACTIVE) && bus.jshift && bus.jce2 &&
                 (shift_len_q != 16'hFFFF)) begin
      shift_len_d = shift_len_q + LEN_W'(1);
    end
    if (state_q == S_UPDATE) last_len_d = shift_len_q;
  end

  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      shift_len_q <= '0;
      last_len_q  <= '0;
    end else begin
      shift_len_q <= shift_len_d;
      last_len_q  <= last_len_d;
    end
  end

  assign bus.shift_len = shift_len_q;
  assign bus.last_len  = last_len_q;
`endif

endmodule

// File: tb/tb_jtag_er2_sched.sv
// Scoreboard bench for jtag_er2_sched: session-level reference model, random plus
// directed traffic, monitor compares every output on the falling edge.
module tb_jtag_er2_sched;

  localparam int unsigned NIP = 15;

  typedef struct {
    logic [NIP-1:0] ce2;
    logic [NIP-1:0] upd;
    logic           tdo;
    logic [3:0]     act;
    logic           busy;
    logic [7:0]     cnt;
    logic [15:0]    sl;
    logic [15:0]    ll;
    int             cyc;
  } exp_t;

  logic jtck;
  logic jrstn;
  int   checks;
  int   failures;
  int   cyc_no;
  exp_t sb[$];

  // Reference session model: locked IP, error flag, IP being updated this cycle
  int m_lock;
  int m_upd;
  bit m_err;
  int m_cnt;
  int m_shift;
  int m_last;

  jtag_er2_sched_if #(.NUM_IP(NIP)) bus ();

  jtag_er2_sched #(.NUM_IP(NIP)) dut (
    .jtck  (jtck),
    .jrstn (jrstn),
    .bus   (bus)
  );

  initial begin
    jtck = 1'b0;
    forever #5 jtck = ~jtck;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc_no, got, exp);
    end
  endfunction

  function automatic int idx_of(logic [NIP-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < int'(NIP); i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic void model_reset();
    m_lock = -1; m_upd = -1; m_err = 1'b0; m_cnt = 0; m_shift = 0; m_last = 0;
  endfunction

  function automatic void push_expect();
    exp_t e;
    int   cur;
    cur = -1;
    if (!m_err && m_upd < 0) begin
      if (m_lock >= 0) cur = m_lock;
      else if ($countones(bus.ip_enable) == 1) cur = idx_of(bus.ip_enable);
    end
    e.ce2  = (bus.jce2 && cur >= 0) ? (NIP'(1) << cur) : '0;
    e.tdo  = (cur >= 0) ? bus.ip_tdo[cur] : 1'b0;
    e.upd  = (m_upd >= 0) ? (NIP'(1) << m_upd) : '0;
    e.act  = (m_upd >= 0) ? 4'(m_upd) : (m_lock >= 0) ? 4'(m_lock) : 4'hF;
    e.busy = (m_lock >= 0) || m_err;
    e.cnt  = 8'(m_cnt);
    e.sl   = 16'(m_shift);
    e.ll   = 16'(m_last);
    e.cyc  = cyc_no;
    sb.push_back(e);
  endfunction

  function automatic void model_step();
    int pc;
    pc = $countones(bus.ip_enable);
    if (m_upd >= 0) begin
      m_last = m_shift;
      m_upd  = -1;
    end else if (m_err) begin
      if (bus.jupdate) m_err = 1'b0;
    end else if (m_lock >= 0) begin
      if (bus.jshift && bus.jce2 && m_shift < 65535) m_shift++;
      if (bus.jupdate) begin
        m_upd  = m_lock;
        m_lock = -1;
      end
    end else if (bus.jce2) begin
      if (pc == 1) begin
        m_lock  = idx_of(bus.ip_enable);
        m_shift = 0;
      end else if (pc > 1) begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endfunction

  // One JTAG cycle: drive just after the rising edge, record expectation, advance model
  task automatic cycle(input bit rstn, input bit ce, input bit sh, input bit up,
                       input logic [NIP-1:0] en);
    @(posedge jtck);
    #1;
    cyc_no++;
    bus.jce2          = ce;
    bus.jshift        = sh;
    bus.jupdate       = up;
    bus.ip_enable     = en;
    bus.ip_tdo        = NIP'($urandom);
    bus.control_datan = 1'($urandom);
    jrstn             = rstn;
    if (!rstn) model_reset();
    push_expect();
    if (rstn) model_step();
  endtask

  // Monitor: compare every registered and combinational output each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge jtck);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ip_ce2",       32'(bus.ip_ce2),       32'(e.ce2));
        chk("er2_tdo",      32'(bus.er2_tdo),      32'(e.tdo));
        chk("ip_update",    32'(bus.ip_update),    32'(e.upd));
        chk("active_ip",    32'(bus.active_ip),    32'(e.act));
        chk("busy",         32'(bus.busy),         32'(e.busy));
        chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(e.cnt));
`ifdef ER2_SHIFT_COUNT_EN
        chk("shift_len",    32'(bus.shift_len),    32'(e.sl));
        chk("last_len",     32'(bus.last_len),     32'(e.ll));
`endif
      end
    end
  end

  initial begin
    logic [NIP-1:0] en;
    checks = 0; failures = 0; cyc_no = 0;
    jrstn = 1'b0;
    bus.jce2 = 1'b0; bus.jshift = 1'b0; bus.jupdate = 1'b0; bus.control_datan = 1'b0;
    bus.ip_enable = '0; bus.ip_tdo = '0;
    model_reset();

    cycle(0, 0, 0, 0, '0);
    @(negedge jtck);
    chk("rst_active_ip", 32'(bus.active_ip), 32'h0000_000F);
    chk("rst_conflict", 32'(bus.conflict_cnt), 32'h0);
    cycle(1, 0, 0, 0, '0);

    // Single session on IP1 with 8 shifts
    cycle(1, 1, 0, 0, 15'h0002);
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 15'h0002);
    @(negedge jtck);
    chk("s1_active_ip", 32'(bus.active_ip), 32'h1);
    chk("s1_ce2", 32'(bus.ip_ce2), 32'h0002);
    cycle(1, 1, 0, 1, 15'h0002);
    cycle(1, 0, 0, 0, 15'h0000);
    @(negedge jtck);
    chk("s1_update", 32'(bus.ip_update), 32'h0002);
    cycle(1, 0, 0, 0, 15'h0000);

    // Conflict into ERROR, release by jupdate
    cycle(1, 1, 0, 0, 15'h0003);
    cycle(1, 1, 0, 0, 15'h0003);
    @(negedge jtck);
    chk("err_busy", 32'(bus.busy), 32'h1);
    chk("err_ce2", 32'(bus.ip_ce2), 32'h0);
    chk("err_cnt", 32'(bus.conflict_cnt), 32'h1);
    cycle(1, 0, 0, 1, 15'h0000);
    cycle(1, 0, 0, 0, 15'h0000);

    // Lock on IP0, ip_enable changes mid-shift
    cycle(1, 1, 0, 0, 15'h0001);
    for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 15'h0002);
    @(negedge jtck);
    chk("lock_ce2", 32'(bus.ip_ce2), 32'h0001);
    chk("lock_tdo", 32'(bus.er2_tdo), 32'(bus.ip_tdo[0]));
    cycle(1, 1, 0, 1, 15'h0002);
    cycle(1, 0, 0, 0, 15'h0000);

    // Asynchronous reset in ACTIVE after 5 shifts
    cycle(1, 1, 0, 0, 15'h0010);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 15'h0010);
    cycle(0, 1, 1, 1, 15'h0010);
    @(negedge jtck);
    chk("mrst_active_ip", 32'(bus.active_ip), 32'h0000_000F);
    chk("mrst_busy", 32'(bus.busy), 32'h0);
    chk("mrst_update", 32'(bus.ip_update), 32'h0);
    cycle(1, 0, 0, 0, 15'h0000);
    cycle(1, 0, 0, 0, 15'h0000);

`ifdef ER2_SHIFT_COUNT_EN
    cycle(1, 1, 0, 0, 15'h0100);
    for (int i = 0; i < 32; i++) cycle(1, 1, 1, 0, 15'h0100);
    cycle(1, 1, 0, 1, 15'h0100);
    cycle(1, 0, 0, 0, 15'h0000);
    cycle(1, 0, 0, 0, 15'h0000);
    @(negedge jtck);
    chk("last_len32", 32'(bus.last_len), 32'd32);
    cycle(1, 1, 1, 0, 15'h0004);
    cycle(1, 1, 0, 0, 15'h0004);
    @(negedge jtck);
    chk("shift_len_clr", 32'(bus.shift_len), 32'd0);
    cycle(1, 0, 0, 1, 15'h0000);
    cycle(1, 0, 0, 0, 15'h0000);
`endif

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0:       en = '0;
        1, 2:    en = NIP'(1) << $urandom_range(0, NIP - 1);
        default: en = NIP'($urandom);
      endcase
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
            1'($urandom), $urandom_range(0, 7) == 0, en);
    end
    cycle(0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);

    // Conflict counter saturation
    for (int n = 0; n < 300; n++) begin
      cycle(1, 1, 0, 0, 15'h0081);
      cycle(1, 0, 0, 1, 15'h0000);
    end
    cycle(1, 0, 0, 0, '0);
    @(negedge jtck);
    chk("cnt_sat", 32'(bus.conflict_cnt), 32'd255);

    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    @(negedge jtck);
    @(negedge jtck);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
